// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one read-only BRAM port between two burst
// requesters (0: pixel reader, 1: coefficient loader). Each grant issues a
// burst of consecutive addresses. Read data comes back with a fixed two-cycle
// latency and is tagged with the owning requester's rvalid/done strobes.
module bram_read_arbiter #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 req_i,
  input  logic [2*ADDRESS_WIDTH-1:0] addr_i,
  input  logic [2*LEN_WIDTH-1:0]     len_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 rvalid_o,
  output logic [1:0]                 done_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       busy_o,
  output logic [ADDRESS_WIDTH-1:0]   bram_addr,
  output logic                       bram_en,
  output logic [3:0]                 bram_we,
  input  logic [DATA_WIDTH-1:0]      data_i
);
  // Stage 1: BRAM output cycle. Stage 2: registered rdata/rvalid cycle.
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  // Tag carried alongside each issued address down the read pipeline.
  typedef struct packed {
    logic own;   // owning requester
    logic last;  // final word of the burst
  } tag_t;

  state_e                   state_q, state_d;
  logic                     run_q;
  logic                     rr_q, rr_d;     // requester favoured on a tie
  logic                     own_q, own_d;   // owner of the current burst
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;   // words still to issue
  logic [1:0]               zdone;
  logic                     sel;
  logic [ADDRESS_WIDTH-1:0] addr_sel;
  logic [LEN_WIDTH-1:0]     len_sel;
  tag_t                     tag_now;

  logic [STAGES:1]          vld_pipe_q;
  tag_t [STAGES:1]          tag_pipe_q;
  logic [DATA_WIDTH-1:0]    rdata_q;

  // A lone request wins outright; a tie goes to the round-robin favourite.
  always_comb begin
    sel = rr_q;
    if (req_i == 2'b01)      sel = 1'b0;
    else if (req_i == 2'b10) sel = 1'b1;
  end

  assign addr_sel = sel ? addr_i[ADDRESS_WIDTH +: ADDRESS_WIDTH] : addr_i[0 +: ADDRESS_WIDTH];
  assign len_sel  = sel ? len_i[LEN_WIDTH +: LEN_WIDTH]         : len_i[0 +: LEN_WIDTH];

  // run_q blocks grants while reset is held and for the first cycle after release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // FSM and burst state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      own_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The grant and the zero-length done are decided combinationally in IDLE.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    gnt_o   = 2'b00;
    zdone   = 2'b00;
    case (state_q)
      IDLE: begin
        if (run_q && (req_i != 2'b00)) begin
          gnt_o[sel] = 1'b1;
          rr_d       = ~sel;
          own_d      = sel;
          addr_d     = addr_sel;
          cnt_d      = len_sel;
          if (len_sel == '0) zdone[sel] = 1'b1;
          else               state_d    = BURST;
        end
      end
      BURST: begin
        addr_d = addr_q + ADDRESS_WIDTH'(1);
        cnt_d  = cnt_q - LEN_WIDTH'(1);
        if (cnt_q == LEN_WIDTH'(1)) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bram_en   = (state_q == BURST);
  assign bram_addr = addr_q;
  assign bram_we   = 4'd0;
  assign busy_o    = (state_q != IDLE);

  assign tag_now = '{own: own_q, last: (cnt_q == LEN_WIDTH'(1))};

  // Read pipeline: shift the valid bit and tag, and capture BRAM data as it emerges.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      rdata_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bram_en};
      tag_pipe_q <= {tag_pipe_q[STAGES-1:1], tag_now};
      if (vld_pipe_q[STAGES-1]) rdata_q <= data_i;
    end
  end

  assign rvalid_o = !vld_pipe_q[STAGES]      ? 2'b00 :
                    tag_pipe_q[STAGES].own   ? 2'b10 : 2'b01;
  assign done_o   = (rvalid_o & {2{tag_pipe_q[STAGES].last}}) | zdone;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Scoreboard bench for bram_read_arbiter. The expected words for a burst are
// queued when its grant is accepted. A negedge monitor pops them as the DUT
// returns read data.
module tb_bram_read_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req;
  logic [2*AW-1:0] addr;
  logic [2*LW-1:0] len;
  logic [1:0]      gnt, rvalid, done;
  logic [DW-1:0]   rdata;
  logic [DW-1:0]   data = '0;
  logic            busy, ben;
  logic [AW-1:0]   baddr;
  logic [3:0]      bwe;

  always #5 clk = ~clk;

  bram_read_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .addr_i(addr), .len_i(len),
    .gnt_o(gnt), .rvalid_o(rvalid), .done_o(done), .rdata_o(rdata), .busy_o(busy),
    .bram_addr(baddr), .bram_en(ben), .bram_we(bwe), .data_i(data)
  );

  function automatic logic [DW-1:0] mem_of(input logic [AW-1:0] a);
    return {a, 6'h2A, ~a};
  endfunction

  // BRAM model: one-cycle registered read.
  always @(posedge clk) if (ben) data <= mem_of(baddr);

  typedef struct { logic [1:0] mask; logic [DW-1:0] d; logic last; } exp_t;
  typedef struct { int k; int cyc; } gl_t;

  exp_t    exp_q[$];
  logic [AW-1:0] aexp_q[$];
  int      lat_q[$];
  gl_t     glog[$];
  int      n_tests = 0, n_fail = 0, cyc = 0;
  int      rv_cnt[2], done_cnt[2], rv_first[2], rv_last[2], done_cyc[2];
  exp_t    m_e;
  logic [AW-1:0] m_a;
  int      m_l;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: address order, read data, latency, done alignment, stray strobes.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) if (gnt[k]) glog.push_back('{k, cyc});
      if (ben) begin
        n_tests++;
        if (aexp_q.size() == 0) begin
          n_fail++; $display("FAIL bram_addr: unexpected access at %h, none required", baddr);
        end else begin
          m_a = aexp_q.pop_front();
          if (baddr !== m_a) begin
            n_fail++; $display("FAIL bram_addr: got %h required %h", baddr, m_a);
          end
        end
        lat_q.push_back(cyc + 2);
      end
      if (rvalid != 2'b00) begin
        n_tests++;
        if (exp_q.size() == 0 || lat_q.size() == 0) begin
          n_fail++; $display("FAIL rvalid: unexpected rvalid=%b done=%b, none required", rvalid, done);
        end else begin
          m_e = exp_q.pop_front();
          m_l = lat_q.pop_front();
          if (rvalid !== m_e.mask || rdata !== m_e.d || done !== (m_e.last ? m_e.mask : 2'b00) || cyc != m_l) begin
            n_fail++;
            $display("FAIL read_word: got rvalid=%b rdata=%h done=%b cyc=%0d required rvalid=%b rdata=%h done=%b cyc=%0d",
                     rvalid, rdata, done, cyc, m_e.mask, m_e.d, (m_e.last ? m_e.mask : 2'b00), m_l);
          end
        end
        for (int k = 0; k < 2; k++) if (rvalid[k]) begin
          if (rv_cnt[k] == 0) rv_first[k] = cyc;
          rv_cnt[k]++;
          rv_last[k] = cyc;
        end
      end else if (done != 2'b00) begin
        n_tests++;
        if (done !== gnt) begin
          n_fail++; $display("FAIL done_without_valid: got done=%b gnt=%b required done=gnt", done, gnt);
        end
      end
      for (int k = 0; k < 2; k++) if (done[k]) begin done_cnt[k]++; done_cyc[k] = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic flush();
    exp_q.delete(); aexp_q.delete(); lat_q.delete();
  endtask

  task automatic clear_stats();
    glog.delete();
    for (int k = 0; k < 2; k++) begin
      rv_cnt[k] = 0; done_cnt[k] = 0; rv_first[k] = 0; rv_last[k] = 0; done_cyc[k] = -1;
    end
  endtask

  task automatic push_burst(input int k);
    logic [AW-1:0] b;
    int n;
    b = addr[k*AW +: AW];
    n = int'(len[k*LW +: LW]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{mask: (k == 1) ? 2'b10 : 2'b01, d: mem_of(b + AW'(i)), last: (i == n-1)});
      aexp_q.push_back(b + AW'(i));
    end
  endtask

  // Drive req bits. A bit drops after its grant unless keep is set. Expectations are queued per grant.
  task automatic req_until(input logic [1:0] mask, input bit keep, input int ncyc);
    logic [1:0] drop;
    req = mask;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      drop = 2'b00;
      for (int k = 0; k < 2; k++) if (gnt[k]) begin
        push_burst(k);
        if (!keep) drop[k] = 1'b1;
      end
      @(posedge clk); #1;
      req = req & ~drop;
    end
    req = 2'b00;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((busy || exp_q.size() != 0 || aexp_q.size() != 0 || lat_q.size() != 0) && c < 200) begin
      @(negedge clk); c++;
    end
    n_tests++;
    if (c >= 200) begin n_fail++; $display("FAIL %s_drain: timeout, got busy=%b required idle with empty queue", name, busy); end
    tick();
  endtask

  task automatic apply_reset();
    req = 2'b00;
    rst_n = 1'b0;
    flush();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    req = 2'b11; addr = '0; len = {8'd1, 8'd1};
    #3 rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({gnt, rvalid, done, busy, ben} !== 8'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got gnt=%b rvalid=%b done=%b busy=%b en=%b required all 0", gnt, rvalid, done, busy, ben);
    end
    n_tests++;
    if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    n_tests++;
    if (baddr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h required 0", baddr); end
    n_tests++;
    if (bwe !== 4'd0) begin n_fail++; $display("FAIL reset_we: got %h required 0", bwe); end
    req = 2'b00;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single();
    clear_stats();
    addr[0 +: AW] = 13'h010; len[0 +: LW] = 8'd4;
    req_until(2'b01, 1'b0, 4);
    wait_drain("single");
    n_tests++;
    if (glog.size() != 1 || glog[0].k != 0) begin
      n_fail++; $display("FAIL single_gnt: got %0d grants (first k=%0d) required 1 grant to 0", glog.size(), (glog.size() > 0) ? glog[0].k : -1);
    end
    n_tests++;
    if (rv_cnt[0] != 4 || rv_cnt[1] != 0 || rv_last[0] - rv_first[0] != 3) begin
      n_fail++; $display("FAIL single_valids: got cnt0=%0d cnt1=%0d span=%0d required 4,0,3", rv_cnt[0], rv_cnt[1], rv_last[0] - rv_first[0]);
    end
    n_tests++;
    if (done_cnt[0] != 1 || done_cyc[0] != rv_last[0]) begin
      n_fail++; $display("FAIL single_done: got cnt=%0d cyc=%0d required 1 at cyc %0d", done_cnt[0], done_cyc[0], rv_last[0]);
    end
    n_tests++;
    if (glog.size() > 0 && rv_first[0] - glog[0].cyc != 3) begin
      n_fail++; $display("FAIL single_latency: got grant-to-rvalid %0d required 3", rv_first[0] - glog[0].cyc);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    clear_stats();
    addr = {13'h040, 13'h020}; len = {8'd2, 8'd2};
    req_until(2'b11, 1'b0, 8);
    wait_drain("contention");
    n_tests++;
    if (glog.size() != 2 || glog[0].k != 0 || glog[1].k != 1) begin
      n_fail++; $display("FAIL contention_order: got %0d grants required 0 then 1", glog.size());
    end
    n_tests++;
    if (glog.size() != 2 || glog[1].cyc != done_cyc[0]) begin
      n_fail++; $display("FAIL contention_gnt1: got cyc=%0d required done0 cyc=%0d", (glog.size() > 1) ? glog[1].cyc : -1, done_cyc[0]);
    end
    n_tests++;
    if (rv_cnt[1] != 2 || rv_first[1] <= rv_last[0]) begin
      n_fail++; $display("FAIL contention_overlap: got first1=%0d last0=%0d cnt1=%0d required first1>last0, cnt1=2", rv_first[1], rv_last[0], rv_cnt[1]);
    end
  endtask

  task automatic test_fairness();
    clear_stats();
    addr = {13'h200, 13'h100}; len = {8'd1, 8'd1};
    req_until(2'b11, 1'b1, 12);
    wait_drain("fairness");
    n_tests++;
    if (glog.size() != 4) begin
      n_fail++; $display("FAIL fair_count: got %0d grants required 4", glog.size());
    end
    for (int i = 0; i < glog.size() && i < 4; i++) begin
      n_tests++;
      if (glog[i].k != (i % 2) || (i > 0 && glog[i].cyc - glog[i-1].cyc != 3)) begin
        n_fail++; $display("FAIL fair_grant%0d: got k=%0d gap=%0d required k=%0d gap=3", i, glog[i].k, (i > 0) ? glog[i].cyc - glog[i-1].cyc : 3, i % 2);
      end
    end
  endtask

  task automatic test_zero();
    bit bad;
    clear_stats();
    addr[AW +: AW] = 13'h0AA; len[LW +: LW] = 8'd0;
    req = 2'b10;
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL zero_gnt: got %b required 10", gnt); end
    n_tests++;
    if (done !== 2'b10 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b required 10,0", done, busy); end
    tick();
    req = 2'b00;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ben !== 1'b0 || rvalid !== 2'b00 || busy !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL zero_quiet: got activity after zero-length grant required none"); end
    tick();
  endtask

  task automatic test_wrap();
    clear_stats();
    addr[0 +: AW] = 13'h1FFE; len[0 +: LW] = 8'd4;
    req_until(2'b01, 1'b0, 4);
    wait_drain("wrap");
    n_tests++;
    if (rv_cnt[0] != 4 || done_cnt[0] != 1) begin
      n_fail++; $display("FAIL wrap_count: got valids=%0d dones=%0d required 4,1", rv_cnt[0], done_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    addr[0 +: AW] = 13'h300; len[0 +: LW] = 8'd8;
    req = 2'b01;
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL mid_gnt: got %b required 01", gnt); end
    if (gnt[0]) push_burst(0);
    tick();
    req = 2'b00;
    tick();
    n_tests++;
    if (ben !== 1'b1 || baddr !== 13'h301) begin n_fail++; $display("FAIL mid_addr2: got en=%b addr=%h required 1,0301", ben, baddr); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({gnt, rvalid, done, busy, ben} !== 8'd0 || baddr !== '0 || rdata !== '0) begin
      n_fail++; $display("FAIL mid_async_clear: got gnt=%b rv=%b done=%b busy=%b en=%b addr=%h rdata=%h required all 0",
                         gnt, rvalid, done, busy, ben, baddr, rdata);
    end
    flush();
    repeat (2) tick();
    rst_n = 1'b1;
    clear_stats();
    repeat (15) tick();
    n_tests++;
    if (rv_cnt[0] + rv_cnt[1] + done_cnt[0] + done_cnt[1] != 0) begin
      n_fail++; $display("FAIL mid_stale: got %0d stale strobes required 0", rv_cnt[0] + rv_cnt[1] + done_cnt[0] + done_cnt[1]);
    end
    addr = {13'h011, 13'h022}; len = {8'd1, 8'd1};
    req_until(2'b11, 1'b0, 8);
    wait_drain("mid");
    n_tests++;
    if (glog.size() == 0 || glog[0].k != 0) begin
      n_fail++; $display("FAIL mid_rr_reset: got first grant k=%0d required 0", (glog.size() > 0) ? glog[0].k : -1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; req = 2'b00; addr = '0; len = '0;
    clear_stats();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_zero();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
